// File: rtl/rtc_sched_pkg.sv
// Shared constants and types for the RTC bus transaction scheduler.
package rtc_sched_pkg;

  localparam logic [7:0] A_SEG    = 8'h21;
  localparam logic [7:0] A_MIN    = 8'h22;
  localparam logic [7:0] A_HORA   = 8'h23;
  localparam logic [7:0] A_DIA    = 8'h24;
  localparam logic [7:0] A_MES    = 8'h25;
  localparam logic [7:0] A_ANO    = 8'h26;
  localparam logic [7:0] A_T_SEG  = 8'h41;
  localparam logic [7:0] A_T_MIN  = 8'h42;
  localparam logic [7:0] A_T_HORA = 8'h43;
  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_CMD    = 8'hF0;

  localparam logic [7:0] C_CLEAR    = 8'h10;
  localparam logic [7:0] C_LATCH    = 8'hF0;
  localparam logic [7:0] C_XFER_T   = 8'hF1;
  localparam logic [7:0] C_XFER_TMR = 8'hF2;

  localparam int unsigned REQ_INIT  = 0;
  localparam int unsigned REQ_TIME  = 1;
  localparam int unsigned REQ_DATE  = 2;
  localparam int unsigned REQ_TIMER = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    K_INIT,
    K_TIME,
    K_DATE,
    K_TIMER,
    K_REFRESH
  } kind_e;

  // Write-byte source for writes, shadow slot for reads.
  typedef enum logic [3:0] {
    DS_NONE,
    DS_CLEAR,
    DS_MODE,
    DS_SEG,
    DS_MIN,
    DS_HORA,
    DS_DIA,
    DS_MES,
    DS_ANO,
    DS_TSEG,
    DS_TMIN,
    DS_THORA,
    DS_XFER_T,
    DS_XFER_TMR,
    DS_LATCH
  } dsel_e;

endpackage

// File: rtl/rtc_seq_rom.sv
// Transaction list per sequence kind: (kind, step) -> {write, addr, data_sel, last}.
module rtc_seq_rom
  import rtc_sched_pkg::*;
(
  input  kind_e       kind,
  input  logic [3:0]  step,
  output logic        write,
  output logic [7:0]  addr,
  output dsel_e       data_sel,
  output logic        last
);

  always_comb begin
    write    = 1'b1;
    addr     = A_CMD;
    data_sel = DS_NONE;
    last     = 1'b0;
    unique case (kind)
      K_INIT: begin
        addr     = A_CTRL;
        data_sel = (step == 4'd0) ? DS_CLEAR : DS_MODE;
        last     = (step != 4'd0);
      end
      K_TIME: begin
        unique case (step)
          4'd0:    begin addr = A_SEG;  data_sel = DS_SEG;  end
          4'd1:    begin addr = A_MIN;  data_sel = DS_MIN;  end
          4'd2:    begin addr = A_HORA; data_sel = DS_HORA; end
          default: begin addr = A_CMD;  data_sel = DS_XFER_T; last = 1'b1; end
        endcase
      end
      K_DATE: begin
        unique case (step)
          4'd0:    begin addr = A_DIA; data_sel = DS_DIA; end
          4'd1:    begin addr = A_MES; data_sel = DS_MES; end
          4'd2:    begin addr = A_ANO; data_sel = DS_ANO; end
          default: begin addr = A_CMD; data_sel = DS_XFER_T; last = 1'b1; end
        endcase
      end
      K_TIMER: begin
        unique case (step)
          4'd0:    begin addr = A_T_SEG;  data_sel = DS_TSEG;  end
          4'd1:    begin addr = A_T_MIN;  data_sel = DS_TMIN;  end
          4'd2:    begin addr = A_T_HORA; data_sel = DS_THORA; end
          default: begin addr = A_CMD;    data_sel = DS_XFER_TMR; last = 1'b1; end
        endcase
      end
      default: begin
        write = (step == 4'd0);
        unique case (step)
          4'd0:    begin addr = A_CMD;    data_sel = DS_LATCH; end
          4'd1:    begin addr = A_SEG;    data_sel = DS_SEG;   end
          4'd2:    begin addr = A_MIN;    data_sel = DS_MIN;   end
          4'd3:    begin addr = A_HORA;   data_sel = DS_HORA;  end
          4'd4:    begin addr = A_DIA;    data_sel = DS_DIA;   end
          4'd5:    begin addr = A_MES;    data_sel = DS_MES;   end
          4'd6:    begin addr = A_ANO;    data_sel = DS_ANO;   end
          4'd7:    begin addr = A_T_SEG;  data_sel = DS_TSEG;  end
          4'd8:    begin addr = A_T_MIN;  data_sel = DS_TMIN;  end
          default: begin addr = A_T_HORA; data_sel = DS_THORA; last = 1'b1; end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates RTC requests and expands each grant into single-byte bus transactions;
// refresh read-back is committed to the outputs atomically.
module rtc_bus_scheduler
  import rtc_sched_pkg::*;
#(
  parameter int unsigned REFRESH_CYC = 1000,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        init_req,
  input  logic        wr_time_req,
  input  logic        wr_date_req,
  input  logic        wr_timer_req,
  input  logic        mode_24,
  input  logic [23:0] time_in,
  input  logic [23:0] date_in,
  input  logic [23:0] timer_in,
  output logic [3:0]  ack,
  output logic        busy,
  output logic        err,
  output logic        cyc_start,
  output logic        cyc_write,
  output logic [7:0]  cyc_addr,
  output logic [7:0]  cyc_wdata,
  input  logic        cyc_done,
  input  logic [7:0]  cyc_rdata,
  output logic [23:0] time_out,
  output logic [23:0] date_out,
  output logic [23:0] timer_out,
  output logic        rd_valid
);

  localparam int unsigned RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic [3:0]    step_q, step_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          pend_q, pend_d;
  logic          fair_q, fair_d;
  logic          snap_mode_q, snap_mode_d;
  logic [23:0]   snap_time_q, snap_time_d;
  logic [23:0]   snap_date_q, snap_date_d;
  logic [23:0]   snap_timer_q, snap_timer_d;
  logic [23:0]   sh_time_q, sh_time_d;
  logic [23:0]   sh_date_q, sh_date_d;
  logic [23:0]   sh_timer_q, sh_timer_d;
  logic [23:0]   time_out_q, time_out_d;
  logic [23:0]   date_out_q, date_out_d;
  logic [23:0]   timer_out_q, timer_out_d;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;

  logic          ref_wrap;
  logic          grant;
  logic          grant_ref;
  logic          rom_write;
  logic [7:0]    rom_addr;
  dsel_e         rom_sel;
  logic          rom_last;
  logic [7:0]    wbyte;

  rtc_seq_rom u_rom (
    .kind     (kind_q),
    .step     (step_q),
    .write    (rom_write),
    .addr     (rom_addr),
    .data_sel (rom_sel),
    .last     (rom_last)
  );

  always_comb begin
    unique case (rom_sel)
      DS_CLEAR:    wbyte = C_CLEAR;
      DS_MODE:     wbyte = {3'b000, snap_mode_q, 4'b0000};
      DS_SEG:      wbyte = snap_time_q[7:0];
      DS_MIN:      wbyte = snap_time_q[15:8];
      DS_HORA:     wbyte = snap_time_q[23:16];
      DS_DIA:      wbyte = snap_date_q[7:0];
      DS_MES:      wbyte = snap_date_q[15:8];
      DS_ANO:      wbyte = snap_date_q[23:16];
      DS_TSEG:     wbyte = snap_timer_q[7:0];
      DS_TMIN:     wbyte = snap_timer_q[15:8];
      DS_THORA:    wbyte = snap_timer_q[23:16];
      DS_XFER_T:   wbyte = C_XFER_T;
      DS_XFER_TMR: wbyte = C_XFER_TMR;
      DS_LATCH:    wbyte = C_LATCH;
      default:     wbyte = '0;
    endcase
  end

  assign ref_wrap = (ref_cnt_q == REF_LAST);

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    step_d       = step_q;
    wait_d       = wait_q;
    ref_cnt_d    = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    fair_d       = fair_q;
    snap_mode_d  = snap_mode_q;
    snap_time_d  = snap_time_q;
    snap_date_d  = snap_date_q;
    snap_timer_d = snap_timer_q;
    sh_time_d    = sh_time_q;
    sh_date_d    = sh_date_q;
    sh_timer_d   = sh_timer_q;
    time_out_d   = time_out_q;
    date_out_d   = date_out_q;
    timer_out_d  = timer_out_q;
    rd_valid_d   = 1'b0;
    err_d        = 1'b0;
    grant        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        grant = 1'b1;
        if (fair_q && pend_q)   kind_d = K_REFRESH;
        else if (init_req)      kind_d = K_INIT;
        else if (wr_time_req)   kind_d = K_TIME;
        else if (wr_date_req)   kind_d = K_DATE;
        else if (wr_timer_req)  kind_d = K_TIMER;
        else if (pend_q)        kind_d = K_REFRESH;
        else                    grant  = 1'b0;
        if (grant) begin
          state_d      = S_ISSUE;
          step_d       = '0;
          fair_d       = 1'b0;
          snap_mode_d  = mode_24;
          // HORA byte is pre-formed here: bit 7 carries the 12 h flag.
          snap_time_d  = {~mode_24, time_in[22:0]};
          snap_date_d  = date_in;
          snap_timer_d = timer_in;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (cyc_done) begin
          state_d = S_NEXT;
          if (!rom_write) begin
            unique case (rom_sel)
              DS_SEG:   sh_time_d[7:0]    = cyc_rdata;
              DS_MIN:   sh_time_d[15:8]   = cyc_rdata;
              DS_HORA:  sh_time_d[23:16]  = cyc_rdata;
              DS_DIA:   sh_date_d[7:0]    = cyc_rdata;
              DS_MES:   sh_date_d[15:8]   = cyc_rdata;
              DS_ANO:   sh_date_d[23:16]  = cyc_rdata;
              DS_TSEG:  sh_timer_d[7:0]   = cyc_rdata;
              DS_TMIN:  sh_timer_d[15:8]  = cyc_rdata;
              DS_THORA: sh_timer_d[23:16] = cyc_rdata;
              default:  ;
            endcase
          end
        end else if (wait_q == TMO_LAST) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          sh_time_d  = '0;
          sh_date_d  = '0;
          sh_timer_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (rom_last) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          step_d  = step_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (kind_q == K_REFRESH) begin
          time_out_d  = sh_time_q;
          date_out_d  = sh_date_q;
          timer_out_d = sh_timer_q;
          rd_valid_d  = 1'b1;
        end else begin
          fair_d = 1'b1;
        end
      end
    endcase

    grant_ref = grant && (kind_d == K_REFRESH);
    pend_d    = ref_wrap ? 1'b1 : (grant_ref ? 1'b0 : pend_q);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      kind_q       <= K_INIT;
      step_q       <= '0;
      wait_q       <= '0;
      ref_cnt_q    <= '0;
      pend_q       <= 1'b0;
      fair_q       <= 1'b0;
      snap_mode_q  <= 1'b0;
      snap_time_q  <= '0;
      snap_date_q  <= '0;
      snap_timer_q <= '0;
      sh_time_q    <= '0;
      sh_date_q    <= '0;
      sh_timer_q   <= '0;
      time_out_q   <= '0;
      date_out_q   <= '0;
      timer_out_q  <= '0;
      rd_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      step_q       <= step_d;
      wait_q       <= wait_d;
      ref_cnt_q    <= ref_cnt_d;
      pend_q       <= pend_d;
      fair_q       <= fair_d;
      snap_mode_q  <= snap_mode_d;
      snap_time_q  <= snap_time_d;
      snap_date_q  <= snap_date_d;
      snap_timer_q <= snap_timer_d;
      sh_time_q    <= sh_time_d;
      sh_date_q    <= sh_date_d;
      sh_timer_q   <= sh_timer_d;
      time_out_q   <= time_out_d;
      date_out_q   <= date_out_d;
      timer_out_q  <= timer_out_d;
      rd_valid_q   <= rd_valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == S_DONE) begin
      unique case (kind_q)
        K_INIT:  ack[REQ_INIT]  = 1'b1;
        K_TIME:  ack[REQ_TIME]  = 1'b1;
        K_DATE:  ack[REQ_DATE]  = 1'b1;
        K_TIMER: ack[REQ_TIMER] = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign cyc_start = (state_q == S_ISSUE);
  assign cyc_write = cyc_start && rom_write;
  assign cyc_addr  = cyc_start ? rom_addr : '0;
  assign cyc_wdata = cyc_write ? wbyte : '0;
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign time_out  = time_out_q;
  assign date_out  = date_out_q;
  assign timer_out = timer_out_q;

endmodule
